// File: rtl/serial_bit_feeder_if.sv
// Valid/ready word handshake into the serial bit feeder.
// The master offers words; the slave consumes them.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector.
// A one-word holding buffer lets back-to-back words stream gaplessly.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  serial_bit_feeder_if.slave in_if,
  input  logic              en,
  output logic              x,
  output logic              x_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full;
  logic [CW-1:0]    cnt;

  logic shifting;
  logic xfer;
  logic last;
  logic [WIDTH-1:0] sh_next;

  assign shifting = (state == S_SHIFT);
  assign xfer     = in_if.in_valid && !buf_full;
  assign last     = shifting && en && (cnt == LAST);

  assign in_if.in_ready = !buf_full;
  assign word_done      = last;
  assign busy           = shifting || buf_full;
  assign x_valid        = shifting;

  always_comb begin
    x = IDLE_BIT;
    if (shifting)
      x = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  end

  assign sh_next = MSB_FIRST ?
    {sh[WIDTH-2:0], 1'b0} :
    {1'b0, sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      sh       <= '0;
      buf_q    <= '0;
      buf_full <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (buf_full) begin
            sh       <= buf_q;
            buf_full <= 1'b0;
            cnt      <= '0;
            state    <= S_SHIFT;
          end else if (xfer) begin
            sh    <= in_if.in_data;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (last) begin
            // buffer wins; in_ready is low then so no transfer collides
            if (buf_full) begin
              sh       <= buf_q;
              buf_full <= 1'b0;
              cnt      <= '0;
            end else if (xfer) begin
              sh  <= in_if.in_data;
              cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            if (en) begin
              sh  <= sh_next;
              cnt <= cnt + CW'(1);
            end
            if (xfer) begin
              buf_q    <= in_if.in_data;
              buf_full <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances
// driven identically and checked against a word-queue model.
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic x0, xv0, wd0, busy0;
  logic x1, xv1, wd1, busy1;

  serial_bit_feeder_if #(.WIDTH(8)) if0 ();
  serial_bit_feeder_if #(.WIDTH(8)) if1 ();

  serial_bit_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .in_if(if0.slave), .en(en),
    .x(x0), .x_valid(xv0), .word_done(wd0), .busy(busy0)
  );

  serial_bit_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_if(if1.slave), .en(en),
    .x(x1), .x_valid(xv1), .word_done(wd1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // model: words accepted but not fully sent, and bit index in the head
  logic [7:0] q[$];
  int         bi = 0;
  logic       last_acc = 1'b0;
  logic       s0, s1;
  logic [7:0] col0, col1;
  logic [15:0] c16_0, c16_1;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic       ev;
    logic [7:0] w;
    ev = (q.size() > 0);
    w  = ev ? q[0] : 8'h00;
    chk("x_msb",   x0,  ev ? w[7-bi] : 1'b0);
    chk("x_lsb",   x1,  ev ? w[bi]   : 1'b1);
    chk("xv_msb",  xv0, ev);
    chk("xv_lsb",  xv1, ev);
    chk("wd_msb",  wd0, ev && en && (bi == 7));
    chk("wd_lsb",  wd1, ev && en && (bi == 7));
    chk("busy_msb", busy0, ev);
    chk("busy_lsb", busy1, ev);
    chk("rdy_msb", if0.in_ready, q.size() < 2);
    chk("rdy_lsb", if1.in_ready, q.size() < 2);
  endtask

  // called at a negedge; returns at the next negedge
  task automatic step(input logic v, input logic [7:0] d,
                      input logic e);
    logic xf;
    if0.in_valid = v;
    if0.in_data  = d;
    if1.in_valid = v;
    if1.in_data  = d;
    en = e;
    #1;
    check_all();
    s0 = x0;
    s1 = x1;
    xf = v && (q.size() < 2);
    last_acc = xf;
    @(posedge clk);
    if (e && q.size() > 0) begin
      if (bi == 7) begin
        void'(q.pop_front());
        bi = 0;
      end else begin
        bi++;
      end
    end
    if (xf) q.push_back(d);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    #1;
    chk("drain_busy_msb", busy0, 1'b0);
    chk("drain_busy_lsb", busy1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic       v;
    logic [7:0] d;
    logic       pend;
    if0.in_valid = 1'b0;
    if0.in_data  = 8'h00;
    if1.in_valid = 1'b0;
    if1.in_data  = 8'h00;
    @(negedge clk);
    #1;
    chk("rst_x_msb", x0, 1'b0);
    chk("rst_x_lsb", x1, 1'b1);
    chk("rst_xv", xv0, 1'b0);
    chk("rst_rdy", if0.in_ready, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single word B0, continuous enable
    step(1'b1, 8'hB0, 1'b1);
    col0 = '0;
    col1 = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      col0 = {col0[6:0], s0};
      col1 = {col1[6:0], s1};
    end
    chk("t1_seq_msb", col0 === 8'hB0, 1'b1);
    chk("t1_seq_lsb", col1 === 8'h0D, 1'b1);
    drain();

    // back-to-back words with a third held off by the full buffer
    step(1'b1, 8'hB0, 1'b1);
    c16_0 = '0;
    c16_1 = '0;
    pend  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) step(1'b1, 8'h0D, 1'b1);
      else if (i == 1 || pend) step(1'b1, 8'h3C, 1'b1);
      else step(1'b0, 8'h00, 1'b1);
      pend = (i >= 1) && !last_acc &&
             (i == 1 || pend);
      c16_0 = {c16_0[14:0], s0};
      c16_1 = {c16_1[14:0], s1};
    end
    chk("t2_seq_msb", c16_0 === 16'hB00D, 1'b1);
    chk("t2_seq_lsb", c16_1 === 16'h0DB0, 1'b1);
    drain();

    // en toggling 1,0 on A5
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 16; i++)
      step(1'b0, 8'h00, (i % 2) == 0);
    drain();

    // async reset mid-word with a word buffered
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t5_xv", xv0, 1'b0);
    chk("t5_x_msb", x0, 1'b0);
    chk("t5_x_lsb", x1, 1'b1);
    chk("t5_rdy", if0.in_ready, 1'b1);
    chk("t5_busy", busy1, 1'b0);
    chk("t5_wd", wd0, 1'b0);
    q.delete();
    bi = 0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'hFF, 1'b1);
    col0 = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      col0 = {col0[6:0], s0};
    end
    chk("t5_ones", col0 === 8'hFF, 1'b1);
    drain();

    // 20 idle cycles
    for (int i = 0; i < 20; i++)
      step(1'b0, 8'h00, 1'($urandom_range(0, 1)));

    // random traffic, holding an unaccepted word stable
    pend = 1'b0;
    d    = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 2) != 0);
        d = 8'($urandom);
      end else begin
        v = 1'b1;
      end
      step(v, d, $urandom_range(0, 3) != 0);
      pend = v && !last_acc;
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
